// File: rtl/shot_sequencer.sv
// shot_sequencer: game-flow controller for the battleship board.
// Owns the cursor, sequences each shot through a req/ack board read, a
// single-cycle write-back of the result, and win/lose evaluation.
//
// Ports:
//   clk, reset             system clock; synchronous active-low reset
//   start_btn, reset_btn   game start / game abort pulses
//   btn_up/down/left/right cursor move pulses (priority up>down>left>right)
//   btn_select             fire at the cursor cell
//   cur_row, cur_col       cursor position, 0..GRID-1
//   cell_rd_req/ack/data   board read handshake (data valid with ack)
//   cell_addr              latched read/write address (row*GRID+col)
//   cell_wr_en/wr_data     one-cycle result write (2 miss, 3 hit)
//   shot_count, hit_count  accepted shots / hits scored
//   hit/miss/repeat_pulse  one-cycle shot outcome
//   win, lose              game result, held in GAME_OVER
//   state                  FSM state code
module shot_sequencer #(
  parameter int unsigned GRID       = 10,
  parameter int unsigned SHIP_CELLS = 17,
  parameter int unsigned MAX_SHOTS  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       reset_btn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  output logic [3:0] cur_row,
  output logic [3:0] cur_col,
  output logic       cell_rd_req,
  output logic [6:0] cell_addr,
  input  logic       cell_rd_ack,
  input  logic [3:0] cell_rd_data,
  output logic       cell_wr_en,
  output logic [3:0] cell_wr_data,
  output logic [6:0] shot_count,
  output logic [4:0] hit_count,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       repeat_pulse,
  output logic       win,
  output logic       lose,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AIM       = 3'd1,
    READ      = 3'd2,
    RESOLVE   = 3'd3,
    CHECK     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic [3:0] LAST_POS   = 4'(GRID - 1);
  localparam logic [4:0] SHIP_LIMIT = 5'(SHIP_CELLS);
  localparam logic [6:0] SHOT_LIMIT = 7'(MAX_SHOTS);

  state_t     state_q;
  state_t     state_d;
  logic       shot_is_hit;
  logic       rd_fresh;
  logic [6:0] sel_addr;

  // Codes 0 (water) and 1 (ship) are untouched cells; anything else is a repeat.
  assign rd_fresh = (cell_rd_data[3:1] == 3'd0);
  assign sel_addr = 7'(cur_row) * 7'(GRID) + 7'(cur_col);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; reset_btn overrides every other input
  always_comb begin
    state_d = state_q;
    if (reset_btn) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start_btn) state_d = AIM;
        AIM:       if (btn_select) state_d = READ;
        READ:      if (cell_rd_ack) state_d = rd_fresh ? RESOLVE : AIM;
        RESOLVE:   state_d = CHECK;
        CHECK: begin
          // counts were updated on the RESOLVE->CHECK edge; win beats lose
          if (hit_count == SHIP_LIMIT)      state_d = GAME_OVER;
          else if (shot_count == SHOT_LIMIT) state_d = GAME_OVER;
          else                               state_d = AIM;
        end
        GAME_OVER: state_d = GAME_OVER;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output logic (decoded from registered state only)
  always_comb begin
    cell_rd_req  = (state_q == READ);
    cell_wr_en   = (state_q == RESOLVE);
    cell_wr_data = '0;
    if (state_q == RESOLVE) cell_wr_data = shot_is_hit ? 4'd3 : 4'd2;
    state = state_q;
  end

  // Datapath: cursor, address latch, counters, outcome pulses, result flags
  always_ff @(posedge clk) begin
    if (!reset || reset_btn) begin
      cur_row      <= '0;
      cur_col      <= '0;
      cell_addr    <= '0;
      shot_is_hit  <= 1'b0;
      shot_count   <= '0;
      hit_count    <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state_q)
        AIM: begin
          if (btn_select) begin
            cell_addr <= sel_addr;
          end else if (btn_up) begin
            if (cur_row != 4'd0) cur_row <= cur_row - 4'd1;
          end else if (btn_down) begin
            if (cur_row != LAST_POS) cur_row <= cur_row + 4'd1;
          end else if (btn_left) begin
            if (cur_col != 4'd0) cur_col <= cur_col - 4'd1;
          end else if (btn_right) begin
            if (cur_col != LAST_POS) cur_col <= cur_col + 4'd1;
          end
        end
        READ: begin
          if (cell_rd_ack) begin
            if (rd_fresh) shot_is_hit  <= (cell_rd_data == 4'd1);
            else          repeat_pulse <= 1'b1;
          end
        end
        RESOLVE: begin
          shot_count <= shot_count + 7'd1;
          if (shot_is_hit) hit_count <= hit_count + 5'd1;
          hit_pulse  <= shot_is_hit;
          miss_pulse <= !shot_is_hit;
        end
        CHECK: begin
          if (hit_count == SHIP_LIMIT)       win  <= 1'b1;
          else if (shot_count == SHOT_LIMIT) lose <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed testbench for shot_sequencer (SHIP_CELLS=2, MAX_SHOTS=3 so that
// win and lose are reachable with a handful of shots).
module tb_shot_sequencer;

  logic       clk = 1'b0;
  logic       reset, start_btn, reset_btn;
  logic       btn_up, btn_down, btn_left, btn_right, btn_select;
  logic [3:0] cur_row, cur_col;
  logic       cell_rd_req;
  logic [6:0] cell_addr;
  logic       cell_rd_ack;
  logic [3:0] cell_rd_data;
  logic       cell_wr_en;
  logic [3:0] cell_wr_data;
  logic [6:0] shot_count;
  logic [4:0] hit_count;
  logic       hit_pulse, miss_pulse, repeat_pulse, win, lose;
  logic [2:0] state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shot_sequencer #(.GRID(10), .SHIP_CELLS(2), .MAX_SHOTS(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .reset_btn(reset_btn),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_select(btn_select),
    .cur_row(cur_row), .cur_col(cur_col),
    .cell_rd_req(cell_rd_req), .cell_addr(cell_addr),
    .cell_rd_ack(cell_rd_ack), .cell_rd_data(cell_rd_data),
    .cell_wr_en(cell_wr_en), .cell_wr_data(cell_wr_data),
    .shot_count(shot_count), .hit_count(hit_count),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .repeat_pulse(repeat_pulse),
    .win(win), .lose(lose), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic press_start();
    start_btn = 1; step(); start_btn = 0;
  endtask

  task automatic press_reset_btn();
    reset_btn = 1; step(); reset_btn = 0;
  endtask

  task automatic check_cursor(input string tag, input int unsigned r, input int unsigned c);
    check({tag, "_row"}, cur_row, r);
    check({tag, "_col"}, cur_col, c);
  endtask

  // Select, hold ack low for lat cycles, then ack with data.
  task automatic shoot(input logic [3:0] data, input int unsigned lat, input int unsigned addr);
    btn_select = 1; step(); btn_select = 0;
    check("sel_state", state, 2);
    check("sel_req", cell_rd_req, 1);
    check("sel_addr", cell_addr, addr);
    repeat (lat) step();
    cell_rd_ack = 1; cell_rd_data = data; step();
    cell_rd_ack = 0; cell_rd_data = 0;
  endtask

  initial begin
    reset = 0; start_btn = 0; reset_btn = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_select = 0;
    cell_rd_ack = 0; cell_rd_data = 0;
    step(); step();
    check("rst_state", state, 0);
    check_cursor("rst", 0, 0);
    check("rst_shots", shot_count, 0);
    check("rst_hits", hit_count, 0);
    check("rst_req", cell_rd_req, 0);
    check("rst_wr", cell_wr_en, 0);
    check("rst_addr", cell_addr, 0);
    check("rst_wdata", cell_wr_data, 0);
    check("rst_flags", {win, lose, hit_pulse, miss_pulse, repeat_pulse}, 0);
    reset = 1;

    // moves ignored in IDLE
    move(0, 1, 0, 1);
    check_cursor("idle_move", 0, 0);
    check("idle_state", state, 0);
    press_start();
    check("start_state", state, 1);

    // first shot: (1,2) -> addr 12, ack one cycle after req, ship
    move(0, 0, 0, 1);
    move(0, 0, 0, 1);
    move(0, 1, 0, 0);
    check_cursor("aim", 1, 2);
    shoot(4'd1, 1, 12);
    check("hit_res_state", state, 3);
    check("hit_wr_en", cell_wr_en, 1);
    check("hit_wdata", cell_wr_data, 3);
    check("hit_wr_addr", cell_addr, 12);
    check("hit_cnt_pre", hit_count, 0);
    step();
    check("hit_chk_state", state, 4);
    check("hit_wr_drop", cell_wr_en, 0);
    check("hit_pulse", hit_pulse, 1);
    check("hit_miss_pulse", miss_pulse, 0);
    check("hit_count1", hit_count, 1);
    check("shot_count1", shot_count, 1);
    step();
    check("hit_back_aim", state, 1);
    check("hit_pulse_drop", hit_pulse, 0);

    // edge saturation
    move(1, 0, 0, 0);
    move(0, 0, 1, 0);
    move(0, 0, 1, 0);
    check_cursor("to_origin", 0, 0);
    move(0, 0, 1, 0);
    move(1, 0, 0, 0);
    check_cursor("sat_origin", 0, 0);
    for (int i = 0; i < 9; i++) move(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) move(0, 0, 0, 1);
    check_cursor("to_corner", 9, 9);
    move(0, 0, 0, 1);
    move(0, 1, 0, 0);
    check_cursor("sat_corner", 9, 9);
    for (int i = 0; i < 4; i++) move(1, 0, 1, 0);  // up wins over left
    check_cursor("up_over_left", 5, 9);
    for (int i = 0; i < 4; i++) move(0, 0, 1, 0);
    check_cursor("at_55", 5, 5);
    move(1, 0, 0, 1);
    check_cursor("up_right", 4, 5);
    move(1, 1, 1, 1);
    check_cursor("all_dirs", 3, 5);
    move(0, 0, 1, 1);
    check_cursor("left_right", 3, 4);

    // repeat shot at 12; select with a move in the same cycle
    move(1, 0, 0, 0);
    move(1, 0, 0, 0);
    move(0, 0, 1, 0);
    move(0, 0, 1, 0);
    check_cursor("back_12", 1, 2);
    btn_up = 1; btn_select = 1; step(); btn_up = 0; btn_select = 0;
    check("rep_state", state, 2);
    check("rep_addr", cell_addr, 12);
    check_cursor("sel_over_move", 1, 2);
    move(0, 1, 0, 0);
    check_cursor("frozen_read", 1, 2);
    cell_rd_ack = 1; cell_rd_data = 4'd3; step();
    cell_rd_ack = 0; cell_rd_data = 0;
    check("rep_state_aim", state, 1);
    check("rep_pulse", repeat_pulse, 1);
    check("rep_wr_en", cell_wr_en, 0);
    check("rep_req_drop", cell_rd_req, 0);
    check("rep_hits", hit_count, 1);
    check("rep_shots", shot_count, 1);
    check("rep_hit_pulse", hit_pulse, 0);
    step();
    check("rep_pulse_drop", repeat_pulse, 0);
    check("rep_wr_en2", cell_wr_en, 0);

    // second hit at (1,3) reaches SHIP_CELLS=2
    move(0, 0, 0, 1);
    shoot(4'd1, 0, 13);
    check("win_wr_en", cell_wr_en, 1);
    check("win_wr_addr", cell_addr, 13);
    step();
    check("win_chk_hits", hit_count, 2);
    check("win_chk_flag", win, 0);
    step();
    check("win_state", state, 5);
    check("win_flag", win, 1);
    check("win_lose_flag", lose, 0);
    btn_select = 1; start_btn = 1; step(); btn_select = 0; start_btn = 0;
    move(0, 0, 0, 1);
    check("go_state", state, 5);
    check("go_req", cell_rd_req, 0);
    check_cursor("go_cursor", 1, 3);
    check("go_win_held", win, 1);
    press_reset_btn();
    check("rb_state", state, 0);
    check_cursor("rb", 0, 0);
    check("rb_counts", {shot_count, hit_count}, 0);
    check("rb_flags", {win, lose}, 0);

    // three misses with MAX_SHOTS=3
    press_start();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) move(0, 0, 0, 1);
      shoot(4'd0, 0, i);
      check("miss_wdata", cell_wr_data, 2);
      check("miss_wr_en", cell_wr_en, 1);
      step();
      check("miss_pulse", miss_pulse, 1);
      check("miss_shots", shot_count, i + 1);
      check("miss_hits", hit_count, 0);
      step();
      check("miss_next_state", state, (i < 2) ? 1 : 5);
    end
    check("lose_flag", lose, 1);
    check("lose_win_flag", win, 0);

    // win and shot limit reached together -> win
    press_reset_btn();
    press_start();
    shoot(4'd0, 0, 0); step(); step();
    move(0, 0, 0, 1);
    shoot(4'd1, 0, 1); step(); step();
    check("wf_mid_state", state, 1);
    move(0, 0, 0, 1);
    shoot(4'd1, 2, 2); step();
    check("wf_hits", hit_count, 2);
    check("wf_shots", shot_count, 3);
    step();
    check("wf_state", state, 5);
    check("wf_win", win, 1);
    check("wf_lose", lose, 0);

    // reset_btn while waiting for a slow ack
    press_reset_btn();
    press_start();
    btn_select = 1; step(); btn_select = 0;
    for (int i = 0; i < 5; i++) begin
      check("wait_req", cell_rd_req, 1);
      step();
    end
    reset_btn = 1; step(); reset_btn = 0;
    check("abort_req", cell_rd_req, 0);
    check("abort_state", state, 0);
    cell_rd_ack = 1; cell_rd_data = 4'd1; step();
    cell_rd_ack = 0; cell_rd_data = 0;
    check("late_ack_wr", cell_wr_en, 0);
    check("late_ack_state", state, 0);
    step();
    check("late_ack_wr2", cell_wr_en, 0);
    check("late_ack_counts", {shot_count, hit_count, hit_pulse}, 0);

    // synchronous reset mid-game
    press_start();
    move(0, 1, 0, 0);
    reset = 0; step(); reset = 1;
    check("sync_rst_state", state, 0);
    check_cursor("sync_rst", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
